// File: rtl/prism_timer_bank.sv
// Purpose : NUM_CH-channel counter/timer bank (one-shot down, auto-reload down,
//           up/compare) with sticky event flags and an OR-ed interrupt.
// Latency : host writes and FSM strobes take effect at the next clk edge;
//           status, irq and read data are combinational from the registers.
//           No backpressure: data_ready is tied high, every access completes at once.
// Ports   : clk/rst (sync, active-high); address/data_in/data_write_n/data_read_n/
//           data_out/data_ready = TinyQV peripheral bus; halt freezes FSM strobes;
//           ch_load/ch_step = per-channel FSM strobes; ch_zero/ch_match = status back
//           to the FSM; irq = OR over channels of (flag & irq_en).
module prism_timer_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        address,
  input  logic [31:0]       data_in,
  input  logic [1:0]        data_write_n,
  input  logic [1:0]        data_read_n,
  output logic [31:0]       data_out,
  output logic              data_ready,
  input  logic              halt,
  input  logic [NUM_CH-1:0] ch_load,
  input  logic [NUM_CH-1:0] ch_step,
  output logic [NUM_CH-1:0] ch_zero,
  output logic [NUM_CH-1:0] ch_match,
  output logic              irq
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_ONE = 2'b01;
  localparam logic [1:0] MODE_ARL = 2'b10;
  localparam logic [1:0] MODE_UP  = 2'b11;

  logic [NUM_CH-1:0][CNT_W-1:0] count_q, count_d;
  logic [NUM_CH-1:0][CNT_W-1:0] reload_q, reload_d;
  logic [NUM_CH-1:0][1:0]       mode_q, mode_d;
  logic [NUM_CH-1:0]            irq_en_q, irq_en_d;
  logic [NUM_CH-1:0]            flag_q, flag_d;
  logic [NUM_CH-1:0]            flag_set;

  logic wr32, wr_ctrl, wr_mode;

  // Reads have no side effects, and only the low CNT_W / NUM_CH bits of a
  // write are ever stored.
  logic unused_bits;
  assign unused_bits = ^{data_read_n, data_in};

  // Narrow (8/16-bit) writes are dropped entirely.
  assign wr32    = (data_write_n == 2'b10);
  assign wr_ctrl = wr32 && (address == 6'h00);
  assign wr_mode = wr32 && (address == 6'h04);

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    irq_en_d = irq_en_q;
    flag_set = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ctrl) irq_en_d[c] = data_in[c];
      if (wr_mode) mode_d[c] = data_in[2*c +: 2];
      if (wr32 && (address == 6'(16 + 8*c))) reload_d[c] = data_in[CNT_W-1:0];

      // Host COUNT write beats load, load beats step. Strobes only act in a
      // live mode while PRISM is running.
      if (wr32 && (address == 6'(20 + 8*c))) begin
        count_d[c] = data_in[CNT_W-1:0];
      end else if (!halt && (mode_q[c] != MODE_OFF) && ch_load[c]) begin
        count_d[c] = (mode_q[c] == MODE_UP) ? '0 : reload_q[c];
      end else if (!halt && (mode_q[c] != MODE_OFF) && ch_step[c]) begin
        case (mode_q[c])
          MODE_ONE: begin
            if (count_q[c] != '0) begin
              count_d[c] = count_q[c] - 1'b1;
              if (count_q[c] == cnt_t'(1)) flag_set[c] = 1'b1;
            end
          end
          MODE_ARL: begin
            // Reaching 1 is the period end; a count of 0 (e.g. after a
            // direct write) just re-arms without an event.
            if (count_q[c] > cnt_t'(1)) begin
              count_d[c] = count_q[c] - 1'b1;
            end else begin
              count_d[c] = reload_q[c];
              if (count_q[c] == cnt_t'(1)) flag_set[c] = 1'b1;
            end
          end
          default: begin
            // Up/compare: wraps naturally at all-ones if RELOAD is unreachable.
            if (count_q[c] == reload_q[c]) begin
              count_d[c]  = '0;
              flag_set[c] = 1'b1;
            end else begin
              count_d[c] = count_q[c] + 1'b1;
            end
          end
        endcase
      end
    end
    // A same-cycle event beats the host's write-1-to-clear.
    flag_d = (flag_q & ~(wr_ctrl ? data_in[8 +: NUM_CH] : '0)) | flag_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= '0;
      irq_en_q <= '0;
      flag_q   <= '0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      irq_en_q <= irq_en_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    data_out = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (address == 6'h00) begin
        data_out[c]     = irq_en_q[c];
        data_out[8 + c] = flag_q[c];
      end
      if (address == 6'h04) data_out[2*c +: 2] = mode_q[c];
      if (address == 6'(16 + 8*c)) data_out = 32'(reload_q[c]);
      if (address == 6'(20 + 8*c)) data_out = 32'(count_q[c]);
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_zero[c]  = (count_q[c] == '0);
      ch_match[c] = (count_q[c] == reload_q[c]);
    end
  end

  assign irq        = |(flag_q & irq_en_q);
  assign data_ready = 1'b1;

endmodule

// File: tb/tb_prism_timer_bank.sv
module tb_prism_timer_bank;

  localparam logic [1:0] W32 = 2'b10;
  localparam logic [1:0] W16 = 2'b01;
  localparam logic [1:0] W8  = 2'b00;
  localparam logic [1:0] NW  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic        halt;
  logic [3:0]  ch_load, ch_step;
  logic [31:0] data_out;
  logic        data_ready;
  logic [3:0]  ch_zero, ch_match;
  logic        irq;

  // Second instance: 2 channels, 4-bit counters, shares the bus.
  logic [1:0]  s_load, s_step;
  logic [31:0] s_data_out;
  logic        s_data_ready;
  logic [1:0]  s_zero, s_match;
  logic        s_irq;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  prism_timer_bank #(.NUM_CH(4), .CNT_W(27)) u_dut (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .halt(halt),
    .ch_load(ch_load), .ch_step(ch_step), .ch_zero(ch_zero),
    .ch_match(ch_match), .irq(irq)
  );

  prism_timer_bank #(.NUM_CH(2), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(s_data_out), .data_ready(s_data_ready), .halt(halt),
    .ch_load(s_load), .ch_step(s_step), .ch_zero(s_zero),
    .ch_match(s_match), .irq(s_irq)
  );

  typedef struct {
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  wn;
    logic [3:0]  ld;
    logic [3:0]  st;
    logic        h;
    logic [5:0]  raddr;
    logic [31:0] exp_rd;
    logic [3:0]  exp_zero;
    logic        exp_irq;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [5:0] wa, input logic [31:0] wd,
                              input logic [1:0] wn, input logic [3:0] ld,
                              input logic [3:0] st, input logic h,
                              input logic [5:0] ra, input logic [31:0] er,
                              input logic [3:0] ez, input logic ei);
    vec_t v;
    v.waddr = wa; v.wdata = wd; v.wn = wn; v.ld = ld; v.st = st; v.h = h;
    v.raddr = ra; v.exp_rd = er; v.exp_zero = ez; v.exp_irq = ei;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // One clock with the given bus/strobe inputs; returns 1ns after the edge
  // with the bus idle again.
  task automatic apply(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn,
                       input logic [3:0] ld, input logic [3:0] st, input logic h);
    @(negedge clk);
    address = a; data_in = d; data_write_n = wn; ch_load = ld; ch_step = st; halt = h;
    @(posedge clk);
    #1;
    data_write_n = NW; data_in = '0; ch_load = '0; ch_step = '0; halt = 1'b0;
    s_load = '0; s_step = '0;
  endtask

  task automatic rd(input logic [5:0] a);
    address = a;
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [5:0] regs [10];
    rst = 1'b1; address = '0; data_in = '0; data_write_n = NW; data_read_n = 2'b11;
    halt = 1'b0; ch_load = '0; ch_step = '0; s_load = '0; s_step = '0;
    regs = '{6'h00, 6'h04, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h20, 6'h24, 6'h28, 6'h2C};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Power-on reset state
    rd(6'h00);
    check("por_ctrl", data_out, 32'h0);
    check("por_zero", {28'b0, ch_zero}, 32'hF);
    check("por_match", {28'b0, ch_match}, 32'hF);
    check("por_irq", {31'b0, irq}, 32'h0);
    check("por_ready", {31'b0, data_ready}, 32'h1);

    //          waddr  wdata          wn   ld    st    h     raddr  exp_rd         zero  irq
    // One-shot on ch0 (MODE: ch0=01 ch1=10 ch2=11 ch3=01)
    vq.push_back(mk(6'h10, 32'd3,         W32, 4'h0, 4'h0, 1'b0, 6'h10, 32'd3,         4'hF, 1'b0));
    vq.push_back(mk(6'h04, 32'h79,        W32, 4'h0, 4'h0, 1'b0, 6'h04, 32'h79,        4'hF, 1'b0));
    vq.push_back(mk(6'h00, 32'hF,         W32, 4'h0, 4'h0, 1'b0, 6'h00, 32'hF,         4'hF, 1'b0));
    vq.push_back(mk(6'h00, 32'h0,         NW,  4'h1, 4'h0, 1'b0, 6'h14, 32'd3,         4'hE, 1'b0));
    vq.push_back(mk(6'h00, 32'h0,         NW,  4'h0, 4'h1, 1'b0, 6'h14, 32'd2,         4'hE, 1'b0));
    vq.push_back(mk(6'h00, 32'h0,         NW,  4'h0, 4'h1, 1'b0, 6'h14, 32'd1,         4'hE, 1'b0));
    vq.push_back(mk(6'h00, 32'h0,         NW,  4'h0, 4'h1, 1'b0, 6'h14, 32'd0,         4'hF, 1'b1));
    vq.push_back(mk(6'h00, 32'h0,         NW,  4'h0, 4'h1, 1'b0, 6'h00, 32'h10F,       4'hF, 1'b1));
    vq.push_back(mk(6'h00, 32'h10F,       W32, 4'h0, 4'h0, 1'b0, 6'h00, 32'hF,         4'hF, 1'b0));
    // Auto-reload on ch1, RELOAD=2
    vq.push_back(mk(6'h18, 32'd2,         W32, 4'h0, 4'h0, 1'b0, 6'h18, 32'd2,         4'hF, 1'b0));
    vq.push_back(mk(6'h00, 32'h0,         NW,  4'h2, 4'h0, 1'b0, 6'h1C, 32'd2,         4'hD, 1'b0));
    vq.push_back(mk(6'h00, 32'h0,         NW,  4'h0, 4'h2, 1'b0, 6'h1C, 32'd1,         4'hD, 1'b0));
    vq.push_back(mk(6'h00, 32'h0,         NW,  4'h0, 4'h2, 1'b0, 6'h1C, 32'd2,         4'hD, 1'b1));
    vq.push_back(mk(6'h00, 32'h0,         NW,  4'h0, 4'h2, 1'b0, 6'h1C, 32'd1,         4'hD, 1'b1));
    vq.push_back(mk(6'h00, 32'h0,         NW,  4'h0, 4'h2, 1'b0, 6'h1C, 32'd2,         4'hD, 1'b1));
    vq.push_back(mk(6'h00, 32'h0,         NW,  4'h0, 4'h2, 1'b0, 6'h1C, 32'd1,         4'hD, 1'b1));
    vq.push_back(mk(6'h00, 32'h20F,       W32, 4'h0, 4'h2, 1'b0, 6'h00, 32'h20F,       4'hD, 1'b1));
    vq.push_back(mk(6'h00, 32'h20F,       W32, 4'h0, 4'h0, 1'b0, 6'h00, 32'hF,         4'hD, 1'b0));
    // Priority and halt on ch3
    vq.push_back(mk(6'h2C, 32'd7,         W32, 4'h8, 4'h8, 1'b0, 6'h2C, 32'd7,         4'h5, 1'b0));
    vq.push_back(mk(6'h00, 32'h0,         NW,  4'h8, 4'h8, 1'b1, 6'h2C, 32'd7,         4'h5, 1'b0));
    vq.push_back(mk(6'h2C, 32'd4,         W32, 4'h0, 4'h8, 1'b1, 6'h2C, 32'd4,         4'h5, 1'b0));
    vq.push_back(mk(6'h00, 32'h0,         NW,  4'h0, 4'h8, 1'b0, 6'h2C, 32'd3,         4'h5, 1'b0));
    // Bus rules
    vq.push_back(mk(6'h10, 32'd9,         W16, 4'h0, 4'h0, 1'b0, 6'h10, 32'd3,         4'h5, 1'b0));
    vq.push_back(mk(6'h10, 32'd9,         W8,  4'h0, 4'h0, 1'b0, 6'h10, 32'd3,         4'h5, 1'b0));
    vq.push_back(mk(6'h14, 32'hFFFFFFFF,  W32, 4'h0, 4'h0, 1'b0, 6'h14, 32'h07FFFFFF,  4'h4, 1'b0));
    vq.push_back(mk(6'h30, 32'd5,         W32, 4'h0, 4'h0, 1'b0, 6'h30, 32'h0,         4'h4, 1'b0));
    vq.push_back(mk(6'h04, 32'hFFFFFF79,  W32, 4'h0, 4'h0, 1'b0, 6'h04, 32'h79,        4'h4, 1'b0));
    vq.push_back(mk(6'h00, 32'hFFFFFFFF,  W32, 4'h0, 4'h0, 1'b0, 6'h00, 32'hF,         4'h4, 1'b0));
    // Mode off: COUNT survives the mode change and strobes are ignored
    vq.push_back(mk(6'h04, 32'h0,         W32, 4'h0, 4'h0, 1'b0, 6'h14, 32'h07FFFFFF,  4'h4, 1'b0));
    vq.push_back(mk(6'h00, 32'h0,         NW,  4'hF, 4'hF, 1'b0, 6'h1C, 32'd2,         4'h4, 1'b0));
    vq.push_back(mk(6'h04, 32'h79,        W32, 4'h0, 4'h0, 1'b0, 6'h04, 32'h79,        4'h4, 1'b0));
    vq.push_back(mk(6'h20, 32'd5,         W32, 4'h0, 4'h0, 1'b0, 6'h20, 32'd5,         4'h4, 1'b0));

    foreach (vq[i]) begin
      apply(vq[i].waddr, vq[i].wdata, vq[i].wn, vq[i].ld, vq[i].st, vq[i].h);
      rd(vq[i].raddr);
      check($sformatf("vec%0d_rd", i), data_out, vq[i].exp_rd);
      check($sformatf("vec%0d_zero", i), {28'b0, ch_zero}, {28'b0, vq[i].exp_zero});
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vq[i].exp_irq});
    end

    // Up/compare on ch2, RELOAD=5: load to 0, count up to 5, then back to 0 with flag
    apply(6'h00, 32'h0, NW, 4'h4, 4'h0, 1'b0);
    rd(6'h24);
    check("up_load", data_out, 32'd0);
    check("up_load_match", {31'b0, ch_match[2]}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      apply(6'h00, 32'h0, NW, 4'h0, 4'h4, 1'b0);
      rd(6'h24);
      check($sformatf("up_cnt%0d", i), data_out, 32'(i));
      check($sformatf("up_match%0d", i), {31'b0, ch_match[2]}, (i == 5) ? 32'd1 : 32'd0);
    end
    apply(6'h00, 32'h0, NW, 4'h0, 4'h4, 1'b0);
    rd(6'h24);
    check("up_wrap_cnt", data_out, 32'd0);
    rd(6'h00);
    check("up_flag", data_out, 32'h40F);
    check("up_irq", {31'b0, irq}, 32'd1);

    // Reset with live state: everything back to zero, flag dropped
    pulse_reset();
    foreach (regs[i]) begin
      rd(regs[i]);
      check($sformatf("rst_reg%0h", regs[i]), data_out, 32'h0);
    end
    check("rst_zero", {28'b0, ch_zero}, 32'hF);
    check("rst_match", {28'b0, ch_match}, 32'hF);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_s_zero", {30'b0, s_zero}, 32'h3);

    // Narrow instance: 4-bit counter, RELOAD=15, wraps 15 -> 0 with flag
    apply(6'h10, 32'd15, W32, 4'h0, 4'h0, 1'b0);
    apply(6'h04, 32'h3, W32, 4'h0, 4'h0, 1'b0);
    apply(6'h14, 32'hFFFFFFFE, W32, 4'h0, 4'h0, 1'b0);
    rd(6'h14);
    check("s_cnt_mask", s_data_out, 32'hE);
    s_step = 2'b01;
    apply(6'h00, 32'h0, NW, 4'h0, 4'h0, 1'b0);
    rd(6'h14);
    check("s_cnt15", s_data_out, 32'hF);
    check("s_match15", {31'b0, s_match[0]}, 32'd1);
    s_step = 2'b01;
    apply(6'h00, 32'h0, NW, 4'h0, 4'h0, 1'b0);
    rd(6'h14);
    check("s_wrap_cnt", s_data_out, 32'h0);
    rd(6'h00);
    check("s_wrap_flag", s_data_out, 32'h100);
    check("s_irq_masked", {31'b0, s_irq}, 32'd0);
    apply(6'h2C, 32'd7, W32, 4'h0, 4'h0, 1'b0);
    rd(6'h2C);
    check("s_unmapped_ch3", s_data_out, 32'h0);
    check("big_ch3_write", data_out, 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
